bist_cla_controller: RTL
========================

// Module: bist_cla_controller
// PURPOSE
//  Sequences one BIST session of the CLA: seeds and steps the pattern generator (TPG),
//  steps the signature analyser (SA), waits for the SA to finish, then compares the
//  signature against a golden value. Sits between the top-level test port and the TPG,
//  CUT and SA. Reports busy/done/pass/fail/timeout.
// PARAMETERS
//  N_PATTERNS  7        patterns applied per session (1..255)
//  CUT_LAT     1        CUT+capture latency in cycles; delay from tpg_en to sa_en (0..3)
//  SIG_W       4        signature width
//  GOLDEN_SIG  4'hA     expected signature, compared on the full SIG_W bits
//  TIMEOUT     16       max cycles in WAIT_SA before declaring a timeout (1..255)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, asynchronous, active-high
//  start       in   1      session request, sampled in IDLE and DONE only
//  abort       in   1      synchronous abort; return to IDLE next edge
//  sa_done     in   1      SA completion level (enc-style); qualified only in WAIT_SA
//  sig_in      in   SIG_W  SA signature; sampled in COMPARE
//  tpg_load    out  1      load TPG seed (SEED only)
//  tpg_en      out  1      advance TPG one pattern (RUN only)
//  sa_clr      out  1      clear SA register/counter (SEED only)
//  sa_en       out  1      SA step enable = tpg_en delayed CUT_LAT cycles
//  pattern_cnt out  8      patterns issued this session
//  busy        out  1      high in SEED..COMPARE
//  done        out  1      high in DONE
//  pass        out  1      valid when done: sig == GOLDEN_SIG and no timeout
//  fail        out  1      valid when done: mismatch or timeout
//  timeout     out  1      valid when done: sa_done absent for TIMEOUT cycles
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; pattern_cnt=0; delay line and timers cleared.
//  - All control outputs are Moore (decoded from registered state/counters).
//  - IDLE: start=1 -> SEED.
//  - SEED (1 cycle): tpg_load=1, sa_clr=1, pattern_cnt<=0, delay line cleared -> RUN.
//  - RUN: tpg_en=1; pattern_cnt++ each cycle; after N_PATTERNS cycles -> DRAIN
//    (or -> WAIT_SA if CUT_LAT=0).
//  - DRAIN: tpg_en=0 for exactly CUT_LAT cycles while delay line flushes -> WAIT_SA.
//  - sa_en pulses total exactly N_PATTERNS; first pulse CUT_LAT cycles after first tpg_en.
//  - WAIT_SA: wait timer counts from 0; sa_done=1 -> COMPARE; timer reaches TIMEOUT
//    with no sa_done -> DONE with fail=1, timeout=1, pass=0.
//  - COMPARE (1 cycle): pass<=(sig_in==GOLDEN_SIG), fail<=!pass, timeout<=0 -> DONE.
//  - DONE: done=1, results held; start=1 -> SEED (results cleared on entry to SEED).
//  - Minimum latency: start edge to done = 3+N_PATTERNS+CUT_LAT edges (11 with defaults).
//  - start outside IDLE/DONE ignored (no restart, no queueing).
//  - abort in any state -> IDLE next edge; outputs cleared as in reset; abort wins over start.
//  - Async rst mid-session: immediate return to reset values; no partial result kept.
//  - sa_done high before WAIT_SA is ignored; if still high on WAIT_SA entry, COMPARE next.
//  - pattern_cnt saturates at N_PATTERNS; wait timer saturates at TIMEOUT.
// STRUCTURE
//  - Package bist_pkg: state enum {IDLE,SEED,RUN,DRAIN,WAIT_SA,COMPARE,DONE} (3-bit),
//    default N_PATTERNS/CUT_LAT/GOLDEN_SIG/TIMEOUT constants, shared with TPG/SA benches.
//  - Sub-module bist_en_delay: CUT_LAT-deep shift register with sync clear (CUT_LAT=0 ->
//    wire-through); produces sa_en from tpg_en.
//  - Top: FSM, pattern counter, wait timer, result registers.
// TESTING
//  1 start pulse, sa_done at WAIT_SA entry, sig_in=4'hA -> done on edge 11, pass=1, fail=0,
//    7 tpg_en, 7 sa_en each 1 cycle later.
//  2 same, sig_in=4'h3 -> done on edge 11, pass=0, fail=1, timeout=0.
//  3 sa_done held 0 -> 16 cycles in WAIT_SA, then done=1, fail=1, timeout=1.
//  4 start re-pulsed during RUN -> ignored, pattern_cnt ends at 7; start in DONE -> SEED,
//    results cleared.
//  5 abort at 4th RUN cycle -> IDLE next edge, tpg_en/sa_en/busy=0, pattern_cnt=0.
//  6 async rst asserted mid-WAIT_SA (between edges) -> outputs 0 immediately; fresh start
//    afterwards gives the scenario-1 result.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and default session constants for the CLA BIST controller
// and the TPG/SA benches.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    WAIT_SA = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } bist_state_t;

  localparam int         DEF_N_PATTERNS = 7;
  localparam int         DEF_CUT_LAT    = 1;
  localparam int         DEF_SIG_W      = 4;
  localparam logic [3:0] DEF_GOLDEN_SIG = 4'hA;
  localparam int         DEF_TIMEOUT    = 16;
  localparam int         PAT_CNT_W      = 8;

endpackage

// File: rtl/bist_cla_controller_if.sv
// Test-port / TPG / SA signal bundle of the BIST controller.
// The slave modport is the controller's view; master is the driving side.
interface bist_cla_controller_if
  import bist_pkg::*;
#(
  parameter int SIG_W = DEF_SIG_W
);
  logic                 start;
  logic                 abort;
  logic                 sa_done;
  logic [SIG_W-1:0]     sig_in;
  logic                 tpg_load;
  logic                 tpg_en;
  logic                 sa_clr;
  logic                 sa_en;
  logic [PAT_CNT_W-1:0] pattern_cnt;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 fail;
  logic                 timeout;

  modport slave (
    input  start, abort, sa_done, sig_in,
    output tpg_load, tpg_en, sa_clr, sa_en, pattern_cnt,
           busy, done, pass, fail, timeout
  );

  modport master (
    output start, abort, sa_done, sig_in,
    input  tpg_load, tpg_en, sa_clr, sa_en, pattern_cnt,
           busy, done, pass, fail, timeout
  );
endinterface

// File: rtl/bist_en_delay.sv
// Delays the TPG step enable by the CUT+capture latency to form the SA step enable.
// A zero-depth line is a plain wire.
module bist_en_delay #(
  parameter int CUT_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic dout
);

  generate
    if (CUT_LAT == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = clk ^ rst ^ clr;
      assign dout      = din;
    end else begin : g_sr
      logic [CUT_LAT-1:0] sr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr <= '0;
        end else if (clr) begin
          sr <= '0;
        end else begin
          sr[0] <= din;
          for (int i = 1; i < CUT_LAT; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end

      assign dout = sr[CUT_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/bist_cla_controller.sv
// Sequences one CLA BIST session: seed, run patterns, drain, wait for SA, compare.
//
// state   | meaning
// IDLE    | no session, outputs cleared
// SEED    | load TPG seed, clear SA (one cycle)
// RUN     | step TPG once per cycle, N_PATTERNS cycles
// DRAIN   | let the enable delay line flush, CUT_LAT cycles
// WAIT_SA | wait for sa_done, bounded by TIMEOUT cycles
// COMPARE | latch signature verdict (one cycle)
// DONE    | results valid and held until next start
module bist_cla_controller
  import bist_pkg::*;
#(
  parameter int               N_PATTERNS = DEF_N_PATTERNS,
  parameter int               CUT_LAT    = DEF_CUT_LAT,
  parameter int               SIG_W      = DEF_SIG_W,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(DEF_GOLDEN_SIG),
  parameter int               TIMEOUT    = DEF_TIMEOUT
) (
  input logic                    clk,
  input logic                    rst,
  bist_cla_controller_if.slave   bus
);

  localparam logic [PAT_CNT_W-1:0] N_PAT      = PAT_CNT_W'(N_PATTERNS);
  localparam logic [PAT_CNT_W-1:0] LAST_PAT   = PAT_CNT_W'(N_PATTERNS - 1);
  localparam logic [7:0]           TMO_SAT    = 8'(TIMEOUT);
  localparam logic [7:0]           LAST_WAIT  = 8'(TIMEOUT - 1);
  localparam logic [1:0]           DRAIN_LOAD = (CUT_LAT > 0) ? 2'(CUT_LAT - 1) : 2'd0;

  bist_state_t          state;
  logic                 tpg_load_q;
  logic                 sa_clr_q;
  logic                 tpg_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 fail_q;
  logic                 timeout_q;
  logic [PAT_CNT_W-1:0] pat_cnt;
  logic [7:0]           wait_cnt;
  logic [1:0]           drain_cnt;
  logic                 sa_en_w;

  // Abort flushes the delay line too, so no stray sa_en follows an abort.
  bist_en_delay #(.CUT_LAT(CUT_LAT)) u_en_delay (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.abort | tpg_load_q),
    .din  (tpg_en_q),
    .dout (sa_en_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tpg_load_q <= 1'b0;
      sa_clr_q   <= 1'b0;
      tpg_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      pat_cnt    <= '0;
      wait_cnt   <= '0;
      drain_cnt  <= '0;
    end else if (bus.abort) begin
      state      <= IDLE;
      tpg_load_q <= 1'b0;
      sa_clr_q   <= 1'b0;
      tpg_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      pat_cnt    <= '0;
      wait_cnt   <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= SEED;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            tpg_load_q <= 1'b1;
            sa_clr_q   <= 1'b1;
            pat_cnt    <= '0;
            wait_cnt   <= '0;
          end
        end
        SEED: begin
          state      <= RUN;
          tpg_load_q <= 1'b0;
          sa_clr_q   <= 1'b0;
          tpg_en_q   <= 1'b1;
        end
        RUN: begin
          if (pat_cnt < N_PAT) pat_cnt <= pat_cnt + 1'b1;
          if (pat_cnt >= LAST_PAT) begin
            tpg_en_q  <= 1'b0;
            wait_cnt  <= '0;
            drain_cnt <= DRAIN_LOAD;
            state     <= (CUT_LAT == 0) ? WAIT_SA : DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) state <= WAIT_SA;
          else                   drain_cnt <= drain_cnt - 1'b1;
        end
        WAIT_SA: begin
          if (bus.sa_done) begin
            state <= COMPARE;
          end else if (wait_cnt >= LAST_WAIT) begin
            wait_cnt  <= TMO_SAT;
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            fail_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        COMPARE: begin
          state     <= DONE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          pass_q    <= (bus.sig_in == GOLDEN_SIG);
          fail_q    <= (bus.sig_in != GOLDEN_SIG);
          timeout_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tpg_load    = tpg_load_q;
  assign bus.sa_clr      = sa_clr_q;
  assign bus.tpg_en      = tpg_en_q;
  assign bus.sa_en       = sa_en_w;
  assign bus.pattern_cnt = pat_cnt;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.timeout     = timeout_q;

endmodule
